// File: rtl/project_seqfetch_v1.sv
// project_seqfetch_v1 -- memory-fetch stage feeding the Blastn sequence reader.
// Latency: first read request 1 cycle after the command; a chunk completed by a
//          response accepted in cycle t is offered in cycle t+2.
// Backpressure: requests limited to p_max_outstanding credits (in flight + queued);
//          ostream stalls hold the packer and, through credits, the request side.
//
// Ports:
//   clk, reset (async, active-low)
//   istream_msg/val/rdy          : command {N[63:32], byte base[31:0]}
//   ostream_msg/val/rdy          : 128-bit chunk, word i in bits [32i+31:32i]
//   mem_reqstream_msg/val/rdy    : 4-byte read requests
//   mem_respstream_msg/val/rdy   : read responses (in request order)
//   done_val                     : one-cycle command-complete pulse
//   stall_count                  : ostream back-pressure cycles
// Optional feature macro: PROJECT_SEQFETCH_STALLCNT_EN (saturating stall counter);
// when undefined stall_count is tied to zero.

package project_seqfetch_v1_pkg;
  localparam logic [2:0] MEM_TYPE_READ = 3'd0;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;
endpackage

// Generic synchronous FIFO (power-of-two depth), registered storage, no bypass.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: none internally; the caller guarantees no push when full.
module project_seqfetch_v1_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             arst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic             empty_o
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      cnt_q;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage is not reset: the count alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign empty_o    = (cnt_q == '0);
endmodule

module project_seqfetch_v1
  import project_seqfetch_v1_pkg::*;
#(
  parameter int unsigned p_max_outstanding = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [63:0]  istream_msg,
  input  logic         istream_val,
  output logic         istream_rdy,
  output logic [127:0] ostream_msg,
  output logic         ostream_val,
  input  logic         ostream_rdy,
  output mem_req_4B_t  mem_reqstream_msg,
  output logic         mem_reqstream_val,
  input  logic         mem_reqstream_rdy,
  input  mem_resp_4B_t mem_respstream_msg,
  input  logic         mem_respstream_val,
  output logic         mem_respstream_rdy,
  output logic         done_val,
  output logic [31:0]  stall_count
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, LAST = 2'd2} state_e;

  state_e       state_q, state_d;
  logic [31:0]  base_q, base_d;
  logic [31:0]  n_q, n_d;
  logic [7:0]   cmd_id_q, cmd_id_d;
  logic [31:0]  issued_q, issued_d;
  logic [31:0]  popped_q, popped_d;
  logic [127:0] pk_dat_q, pk_dat_d;
  logic         ostream_val_q, ostream_val_d;
  logic         istream_rdy_q, istream_rdy_d;
  logic         resp_rdy_q;
  logic         done_q, done_d;

  logic         cmd_hs, req_can, req_hs, resp_hs, push, pop, ost_hs;
  logic         q_empty;
  logic [31:0]  q_head;
  mem_req_4B_t  req_msg;
  logic         resp_fields_unused;

  assign cmd_hs  = istream_val && istream_rdy_q;
  // Credits cover both requests in flight and words waiting in the queue,
  // so the queue (depth p_max_outstanding) can never overflow.
  assign req_can = (state_q == RUN) && (issued_q != n_q) &&
                   ((issued_q - popped_q) < p_max_outstanding);
  assign req_hs  = req_can && mem_reqstream_rdy;
  assign resp_hs = mem_respstream_val && resp_rdy_q;
  // Stale responses (aborted command or arriving in IDLE) are swallowed here.
  assign push    = resp_hs && (state_q != IDLE) && (mem_respstream_msg.opaque == cmd_id_q);
  // No pop while a chunk is offered: the clearing handshake and the next pop
  // are always in separate cycles.
  assign pop     = (state_q == RUN) && !q_empty && !ostream_val_q && (popped_q != n_q);
  assign ost_hs  = ostream_val_q && ostream_rdy;

  assign resp_fields_unused = ^{mem_respstream_msg.type_, mem_respstream_msg.test,
                                mem_respstream_msg.len};

  project_seqfetch_v1_fifo #(
    .WIDTH (32),
    .DEPTH (p_max_outstanding)
  ) u_resp_q (
    .clk_i      (clk),
    .arst_ni    (reset),
    .push_i     (push),
    .push_dat_i (mem_respstream_msg.data),
    .pop_i      (pop),
    .head_dat_o (q_head),
    .empty_o    (q_empty)
  );

  // Request message is forced to zero whenever it is not valid; while stalled
  // it is a function of state that only changes on its own handshake.
  always_comb begin
    req_msg = '0;
    if (req_can) begin
      req_msg.type_  = MEM_TYPE_READ;
      req_msg.opaque = cmd_id_q;
      req_msg.addr   = base_q + {issued_q[29:0], 2'b00};
    end
  end

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    n_d           = n_q;
    cmd_id_d      = cmd_id_q;
    issued_d      = issued_q;
    popped_d      = popped_q;
    pk_dat_d      = pk_dat_q;
    ostream_val_d = ostream_val_q;
    done_d        = 1'b0;

    // Clearing to zero makes unused slots of a final partial chunk read as 0.
    if (ost_hs) begin
      ostream_val_d = 1'b0;
      pk_dat_d      = '0;
    end

    case (state_q)
      IDLE: begin
        if (cmd_hs) begin
          base_d   = istream_msg[31:0];
          n_d      = istream_msg[63:32];
          cmd_id_d = cmd_id_q + 8'd1;
          issued_d = '0;
          popped_d = '0;
          if (istream_msg[63:32] == 32'd0) done_d  = 1'b1;
          else                             state_d = RUN;
        end
      end
      RUN: begin
        if (req_hs) issued_d = issued_q + 32'd1;
        if (pop) begin
          popped_d = popped_q + 32'd1;
          pk_dat_d[{popped_q[1:0], 5'd0} +: 32] = q_head;
          if ((popped_q[1:0] == 2'd3) || (popped_d == n_q)) ostream_val_d = 1'b1;
          if (popped_d == n_q) state_d = LAST;
        end
      end
      LAST: begin
        if (ost_hs) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    istream_rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      base_q        <= '0;
      n_q           <= '0;
      cmd_id_q      <= '0;
      issued_q      <= '0;
      popped_q      <= '0;
      pk_dat_q      <= '0;
      ostream_val_q <= 1'b0;
      istream_rdy_q <= 1'b0;
      resp_rdy_q    <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      n_q           <= n_d;
      cmd_id_q      <= cmd_id_d;
      issued_q      <= issued_d;
      popped_q      <= popped_d;
      pk_dat_q      <= pk_dat_d;
      ostream_val_q <= ostream_val_d;
      istream_rdy_q <= istream_rdy_d;
      resp_rdy_q    <= 1'b1;
      done_q        <= done_d;
    end
  end

`ifdef PROJECT_SEQFETCH_STALLCNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (ostream_val_q && !ostream_rdy && (stall_q != 32'hFFFF_FFFF)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_count = stall_q;
`else
  assign stall_count = '0;
`endif

  assign istream_rdy        = istream_rdy_q;
  assign ostream_msg        = pk_dat_q;
  assign ostream_val        = ostream_val_q;
  assign mem_reqstream_msg  = req_msg;
  assign mem_reqstream_val  = req_can;
  assign mem_respstream_rdy = resp_rdy_q;
  assign done_val           = done_q;
endmodule

// File: tb/tb_project_seqfetch_v1.sv
// Directed bench for project_seqfetch_v1: delayed in-order memory model,
// handshake monitor, and a linear sequence of checked steps.
module tb_project_seqfetch_v1;
  import project_seqfetch_v1_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic [63:0]  istream_msg;
  logic         istream_val;
  logic         istream_rdy;
  logic [127:0] ostream_msg;
  logic         ostream_val;
  logic         ostream_rdy;
  mem_req_4B_t  mem_reqstream_msg;
  logic         mem_reqstream_val;
  logic         mem_reqstream_rdy;
  mem_resp_4B_t mem_respstream_msg;
  logic         mem_respstream_val;
  logic         mem_respstream_rdy;
  logic         done_val;
  logic [31:0]  stall_count;

  always #5 clk = ~clk;

  project_seqfetch_v1 #(.p_max_outstanding(4)) dut (
    .clk                (clk),
    .reset              (reset),
    .istream_msg        (istream_msg),
    .istream_val        (istream_val),
    .istream_rdy        (istream_rdy),
    .ostream_msg        (ostream_msg),
    .ostream_val        (ostream_val),
    .ostream_rdy        (ostream_rdy),
    .mem_reqstream_msg  (mem_reqstream_msg),
    .mem_reqstream_val  (mem_reqstream_val),
    .mem_reqstream_rdy  (mem_reqstream_rdy),
    .mem_respstream_msg (mem_respstream_msg),
    .mem_respstream_val (mem_respstream_val),
    .mem_respstream_rdy (mem_respstream_rdy),
    .done_val           (done_val),
    .stall_count        (stall_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int           due;
    mem_resp_4B_t r;
  } pend_t;

  pend_t        pend_q[$];
  logic [31:0]  req_addr_q[$];
  logic [127:0] chunk_q[$];
  int cyc = 0, resp_delay = 1;
  int done_cnt = 0, last_done_cyc = -1, last_chunk_cyc = -1, cmd_cyc = -1;
  int inflight = 0, max_inflight = 0, bad_req = 0, unstable = 0;
  logic [127:0] prev_msg = '0;
  logic         prev_stall = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'h1000;
    if (a >= 32'h1000 && a < 32'h1010) return 32'h11 * ({30'd0, off[3:2]} + 32'd1);
    return a ^ 32'hDEAD_0000;
  endfunction

  function automatic logic [127:0] exp_chunk(input logic [31:0] base, input int k);
    logic [127:0] c;
    for (int i = 0; i < 4; i++) c[32*i +: 32] = mem_word(base + 32'(16*k + 4*i));
    return c;
  endfunction

  // Monitor and memory-model bookkeeping on the active edge (pre-edge values).
  always @(posedge clk) begin
    pend_t p;
    if (istream_val && istream_rdy) cmd_cyc = cyc;
    if (mem_respstream_val && mem_respstream_rdy) begin
      void'(pend_q.pop_front());
      inflight--;
    end
    if (mem_reqstream_val && mem_reqstream_rdy) begin
      req_addr_q.push_back(mem_reqstream_msg.addr);
      p.due = cyc + resp_delay;
      p.r = '0;
      p.r.opaque = mem_reqstream_msg.opaque;
      p.r.data = mem_word(mem_reqstream_msg.addr);
      pend_q.push_back(p);
      inflight++;
      if (mem_reqstream_msg.type_ != 3'd0 || mem_reqstream_msg.len != 2'd0 ||
          mem_reqstream_msg.data != 32'd0) bad_req++;
    end
    if (!mem_reqstream_val && mem_reqstream_msg != '0) bad_req++;
    if (inflight > max_inflight) max_inflight = inflight;
    if (ostream_val && ostream_rdy) begin
      chunk_q.push_back(ostream_msg);
      last_chunk_cyc = cyc;
    end
    if (prev_stall && ostream_msg !== prev_msg) unstable++;
    prev_stall = ostream_val && !ostream_rdy;
    prev_msg   = ostream_msg;
    if (done_val) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    cyc++;
  end

  // Memory response driver: head of the in-order queue once its delay expires.
  always @(negedge clk) begin
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      mem_respstream_val = 1'b1;
      mem_respstream_msg = pend_q[0].r;
    end else begin
      mem_respstream_val = 1'b0;
      mem_respstream_msg = '0;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns at the negedge of the cycle after the command handshake.
  task automatic send_cmd(input logic [31:0] base, input logic [31:0] n);
    int g = 0;
    istream_msg = {n, base};
    istream_val = 1'b1;
    while (!istream_rdy && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("cmd_accept", 128'(g < 100), 128'd1);
    @(negedge clk);
    istream_val = 1'b0;
    istream_msg = '0;
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int g = 0;
    while (done_cnt < target && g < budget) begin
      @(negedge clk);
      g++;
    end
    check(tag, 128'(done_cnt >= target), 128'd1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no completion, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nreq, nchk;
    int g;
    logic [127:0] exp;
    reset = 1'b0;
    istream_val = 1'b0;
    istream_msg = '0;
    ostream_rdy = 1'b1;
    mem_reqstream_rdy = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_istream_rdy", 128'(istream_rdy), 128'd0);
    check("rst_ostream_val", 128'(ostream_val), 128'd0);
    check("rst_req_val", 128'(mem_reqstream_val), 128'd0);
    check("rst_resp_rdy", 128'(mem_respstream_rdy), 128'd0);
    check("rst_done", 128'(done_val), 128'd0);
    check("rst_ostream_msg", ostream_msg, 128'd0);
    check("rst_req_msg", 128'(mem_reqstream_msg), 128'd0);
    check("rst_stall", 128'(stall_count), 128'd0);
    reset = 1'b1;
    @(negedge clk);
    check("rel_istream_rdy", 128'(istream_rdy), 128'd1);
    check("rel_resp_rdy", 128'(mem_respstream_rdy), 128'd1);

    // Test 1: N=4 at 0x1000, single chunk
    send_cmd(32'h1000, 32'd4);
    check("t1_first_req_val", 128'(mem_reqstream_val), 128'd1);
    check("t1_first_req_addr", 128'(mem_reqstream_msg.addr), 128'h1000);
    check("t1_istream_rdy_low", 128'(istream_rdy), 128'd0);
    wait_done(1, 200, "t1_done_seen");
    check("t1_nreq", 128'(req_addr_q.size()), 128'd4);
    for (int i = 0; i < 4 && i < req_addr_q.size(); i++)
      check("t1_req_addr", 128'(req_addr_q[i]), 128'(32'h1000 + 32'(4*i)));
    check("t1_nchunk", 128'(chunk_q.size()), 128'd1);
    if (chunk_q.size() > 0)
      check("t1_chunk", chunk_q[0], 128'h00000044_00000033_00000022_00000011);
    check("t1_done_cnt", 128'(done_cnt), 128'd1);
    check("t1_done_timing", 128'(last_done_cyc), 128'(last_chunk_cyc + 1));

    // Test 2: N=6 at 0x2000, first request stalled 3 cycles
    mem_reqstream_rdy = 1'b0;
    send_cmd(32'h2000, 32'd6);
    check("t2_req_val", 128'(mem_reqstream_val), 128'd1);
    check("t2_req_addr", 128'(mem_reqstream_msg.addr), 128'h2000);
    repeat (3) @(negedge clk);
    check("t2_stalled_val", 128'(mem_reqstream_val), 128'd1);
    check("t2_stalled_addr", 128'(mem_reqstream_msg.addr), 128'h2000);
    mem_reqstream_rdy = 1'b1;
    wait_done(2, 200, "t2_done_seen");
    check("t2_nreq", 128'(req_addr_q.size()), 128'd10);
    check("t2_nchunk", 128'(chunk_q.size()), 128'd3);
    if (chunk_q.size() >= 3) begin
      check("t2_chunk0", chunk_q[1], 128'hDEAD200C_DEAD2008_DEAD2004_DEAD2000);
      check("t2_chunk1", chunk_q[2], 128'h00000000_00000000_DEAD2014_DEAD2010);
    end
    check("t2_done_timing", 128'(last_done_cyc), 128'(last_chunk_cyc + 1));

    // Test 3: N=0
    nreq = req_addr_q.size();
    nchk = chunk_q.size();
    send_cmd(32'h7000, 32'd0);
    check("t3_done_c1", 128'(done_val), 128'd1);
    check("t3_istream_rdy", 128'(istream_rdy), 128'd1);
    repeat (6) @(negedge clk);
    check("t3_done_cnt", 128'(done_cnt), 128'd3);
    check("t3_done_timing", 128'(last_done_cyc), 128'(cmd_cyc + 1));
    check("t3_no_req", 128'(req_addr_q.size()), 128'(nreq));
    check("t3_no_chunk", 128'(chunk_q.size()), 128'(nchk));

    // Test 4: N=16 at 0x3000, 10-cycle memory latency, credit limit 4
    resp_delay = 10;
    max_inflight = 0;
    nchk = chunk_q.size();
    send_cmd(32'h3000, 32'd16);
    wait_done(4, 800, "t4_done_seen");
    check("t4_nchunk", 128'(chunk_q.size()), 128'(nchk + 4));
    for (int k = 0; k < 4 && nchk + k < chunk_q.size(); k++)
      check("t4_chunk", chunk_q[nchk + k], exp_chunk(32'h3000, k));
    check("t4_max_inflight", 128'(max_inflight), 128'd4);
    check("t4_done_cnt", 128'(done_cnt), 128'd4);

    // Test 5: N=8 at 0x4000, ostream held off 20 cycles
    resp_delay = 1;
    ostream_rdy = 1'b0;
    nchk = chunk_q.size();
    send_cmd(32'h4000, 32'd8);
    g = 0;
    while (!ostream_val && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("t5_val_seen", 128'(ostream_val), 128'd1);
    repeat (20) @(negedge clk);
    check("t5_held_msg", ostream_msg, 128'hDEAD400C_DEAD4008_DEAD4004_DEAD4000);
    ostream_rdy = 1'b1;
    wait_done(5, 200, "t5_done_seen");
`ifdef PROJECT_SEQFETCH_STALLCNT_EN
    exp = 128'd20;
`else
    exp = 128'd0;
`endif
    check("t5_stall_count", 128'(stall_count), exp);
    check("t5_stable", 128'(unstable), 128'd0);
    check("t5_nchunk", 128'(chunk_q.size()), 128'(nchk + 2));
    if (chunk_q.size() >= nchk + 2) begin
      check("t5_chunk0", chunk_q[nchk], 128'hDEAD400C_DEAD4008_DEAD4004_DEAD4000);
      check("t5_chunk1", chunk_q[nchk + 1], 128'hDEAD401C_DEAD4018_DEAD4014_DEAD4010);
    end

    // Test 6: reset mid-RUN, new command while stale responses still arrive
    resp_delay = 15;
    send_cmd(32'h5000, 32'd8);
    repeat (6) @(negedge clk);
    reset = 1'b0;
    #1;
    check("t6_rst_req_val", 128'(mem_reqstream_val), 128'd0);
    check("t6_rst_istream_rdy", 128'(istream_rdy), 128'd0);
    check("t6_rst_stall", 128'(stall_count), 128'd0);
    check("t6_rst_done", 128'(done_val), 128'd0);
    check("t6_stale_pending", 128'(pend_q.size() > 0), 128'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    resp_delay = 3;
    nchk = chunk_q.size();
    send_cmd(32'h6000, 32'd4);
    wait_done(6, 300, "t6_done_seen");
    g = 0;
    while (pend_q.size() > 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    repeat (5) @(negedge clk);
    check("t6_drained", 128'(pend_q.size()), 128'd0);
    check("t6_done_cnt", 128'(done_cnt), 128'd6);
    check("t6_nchunk", 128'(chunk_q.size()), 128'(nchk + 1));
    if (chunk_q.size() > nchk)
      check("t6_chunk", chunk_q[nchk], 128'hDEAD600C_DEAD6008_DEAD6004_DEAD6000);

    check("req_format", 128'(bad_req), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
